// File: rtl/truth_table_sweeper.sv
// ============================================================================
// truth_table_sweeper : exhaustive stimulus + golden-table checker  | rev 1.0
// ============================================================================
`default_nettype none

module truth_table_sweeper #(
  parameter int                          N_IN     = 3,
  parameter int                          N_OUT    = 1,
  parameter int                          HOLD     = 10,
  parameter bit                          GRAY     = 1'b0,
  parameter logic [N_OUT*(2**N_IN)-1:0]  EXPECTED = 8'b11101000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [N_OUT-1:0]  dut_out,
  output logic [N_IN-1:0]   dut_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              first_fail_valid,
  output logic [N_IN-1:0]   first_fail_vec
);

  localparam int              HW          = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0]   C_HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N_IN-1:0] C_STEP_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   step_q, step_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     err_q, err_d;
  logic              ffv_q, ffv_d;
  logic [N_IN-1:0]   ffvec_q, ffvec_d;

  logic [N_OUT-1:0]  exp_tbl [2**N_IN];
  logic [N_IN-1:0]   vec_cur;

  function automatic logic [N_IN-1:0] vec_of(input logic [N_IN-1:0] s);
    return GRAY ? (s ^ (s >> 1)) : s;
  endfunction

  // Unpack the flat golden table so it can be indexed by the input value.
  for (genvar g = 0; g < 2**N_IN; g++) begin : g_tbl
    assign exp_tbl[g] = EXPECTED[g*N_OUT +: N_OUT];
  end

  assign vec_cur = vec_of(step_q);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    hold_d   = hold_q;
    dut_in_d = dut_in_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_DRIVE;
          step_d   = '0;
          hold_d   = '0;
          dut_in_d = vec_of('0);
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = '0;
          ffv_d    = 1'b0;
          ffvec_d  = '0;
        end
      end
      S_DRIVE: begin
        if (hold_q == C_HOLD_LAST) begin
          if (dut_out != exp_tbl[vec_cur]) begin
            err_d = err_q + 1'b1;
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = vec_cur;
            end
          end
          hold_d = '0;
          // The terminal compare lands in err_d, so pass reflects it.
          if (step_q == C_STEP_LAST) begin
            state_d  = S_DONE;
            step_d   = '0;
            dut_in_d = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pass_d   = (err_d == '0);
          end else begin
            step_d   = step_q + 1'b1;
            dut_in_d = vec_of(step_q + 1'b1);
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      hold_q   <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      hold_q   <= hold_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
    end
  end

  assign dut_in           = dut_in_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

`default_nettype wire
